wave_capture_buffer: RTL and testbench

Parametrised successor to the single-channel scope waveform store. It records microphone samples into a record memory, plays them back, and fills a display-point memory that the VGA pixel logic reads by column index. New over the previous generation: level trigger, freeze-after-frame, fast clear, bar-mode quantisation, reset, and a registered read port for BRAM inference. It sits between the mic sampler/tick dividers and the waveform-draw pixel logic.

---
 rtl/wave_capture_buffer.sv | 235 +++++++++++++++++++++++
 tb/tb_wave_capture_buffer.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_capture_buffer.sv
// Scope waveform store: record/playback sample memory feeding a display-point
// memory with level trigger, freeze-after-frame, fast clear and bar mode.
module wave_capture_buffer #(
    parameter int DATA_W    = 8,
    parameter int REC_DEPTH = 30000,
    parameter int DISP_PTS  = 960,
    parameter int BAR_W     = 16,
    parameter int CLEAR_VAL = 0
) (
    input  logic                             clk_sample,
    input  logic                             rst_n,
    input  logic                             sample_tick,
    input  logic                             record_tick,
    input  logic [DATA_W-1:0]                wave_sample,
    input  logic                             mode_record,
    input  logic                             mode_playback,
    input  logic                             mode_freeze,
    input  logic                             mode_clear,
    input  logic                             mode_bar,
    input  logic                             trig_en,
    input  logic [DATA_W-1:0]                trig_level,
    input  logic [$clog2(DISP_PTS)-1:0]      rd_addr,
    output logic [DATA_W-1:0]                rd_data,
    output logic [$clog2(REC_DEPTH+1)-1:0]   rec_count,
    output logic                             rec_full,
    output logic                             play_done,
    output logic                             frame_done,
    output logic                             busy_clear
);

    localparam int AW = $clog2(REC_DEPTH);
    localparam int CW = $clog2(REC_DEPTH+1);
    localparam int PW = $clog2(DISP_PTS);
    localparam logic [CW-1:0]     DEPTH_C = CW'(REC_DEPTH);
    localparam logic [AW-1:0]     CLR_END = AW'(REC_DEPTH - 1);
    localparam logic [PW-1:0]     PT_LAST = PW'(DISP_PTS - 1);
    localparam logic [DATA_W-1:0] CLR_C   = DATA_W'(CLEAR_VAL);

    typedef enum logic [1:0] {R_IDLE, R_REC, R_FULL, R_CLEAR} rec_st_e;
    typedef enum logic [1:0] {D_ARM, D_FILL, D_HOLD} disp_st_e;

    logic [DATA_W-1:0] rec_mem  [REC_DEPTH];
    logic [DATA_W-1:0] disp_mem [DISP_PTS];

    rec_st_e           rec_st_q, rec_st_d;
    logic [CW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     rec_cnt_q, rec_cnt_d;
    logic [AW-1:0]     clr_ptr_q, clr_ptr_d;
    logic [CW-1:0]     play_ptr_q, play_ptr_d;
    logic              play_done_q, play_done_d;
    disp_st_e          disp_st_q, disp_st_d;
    logic [PW-1:0]     pt_q, pt_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              bar_on_q, bar_on_d;
    logic [DATA_W-1:0] bar_hold_q, bar_hold_d;
    logic              frame_done_q, frame_done_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic              rec_we;
    logic [AW-1:0]     rec_waddr;
    logic [DATA_W-1:0] rec_wdata;
    logic              play_act;
    logic [DATA_W-1:0] play_val;
    logic              src_vld;
    logic [DATA_W-1:0] src_val;
    logic              crossing;
    logic              grp_start;
    logic              disp_we;
    logic [DATA_W-1:0] disp_wdata;

    always_comb begin
        rec_st_d  = rec_st_q;
        wr_ptr_d  = wr_ptr_q;
        rec_cnt_d = rec_cnt_q;
        clr_ptr_d = clr_ptr_q;
        rec_we    = 1'b0;
        rec_waddr = wr_ptr_q[AW-1:0];
        rec_wdata = wave_sample;
        unique case (rec_st_q)
            R_IDLE: begin
                if (mode_clear) begin
                    rec_st_d  = R_CLEAR;
                    clr_ptr_d = '0;
                end else if (mode_record) begin
                    rec_st_d  = R_REC;
                    wr_ptr_d  = '0;
                    rec_cnt_d = '0;
                end
            end
            R_REC: begin
                if (!mode_record) begin
                    rec_st_d = R_IDLE;
                end else if (record_tick && wr_ptr_q < DEPTH_C) begin
                    rec_we    = 1'b1;
                    wr_ptr_d  = wr_ptr_q + 1'b1;
                    rec_cnt_d = rec_cnt_q + 1'b1;
                    if (rec_cnt_q + 1'b1 == DEPTH_C) rec_st_d = R_FULL;
                end
            end
            R_FULL: begin
                if (!mode_record) rec_st_d = R_IDLE;
            end
            R_CLEAR: begin
                // runs to completion regardless of mode_clear
                rec_we    = 1'b1;
                rec_waddr = clr_ptr_q;
                rec_wdata = CLR_C;
                if (clr_ptr_q == CLR_END) begin
                    rec_st_d  = R_IDLE;
                    rec_cnt_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        play_act = mode_playback && rec_st_q != R_REC &&
                   rec_st_q != R_CLEAR && rec_cnt_q != '0;
        play_ptr_d  = play_ptr_q;
        play_done_d = play_done_q;
        play_val    = CLR_C;
        if (!play_act) begin
            play_ptr_d  = '0;
            play_done_d = 1'b0;
        end else if (record_tick) begin
            if (play_ptr_q < rec_cnt_q) begin
                play_val   = rec_mem[play_ptr_q[AW-1:0]];
                play_ptr_d = play_ptr_q + 1'b1;
            end else begin
                play_done_d = 1'b1;
            end
        end
        src_vld = play_act ? record_tick : sample_tick;
        src_val = play_act ? play_val : wave_sample;
    end

    always_comb begin
        disp_st_d    = disp_st_q;
        pt_d         = pt_q;
        prev_d       = prev_q;
        bar_on_d     = bar_on_q;
        bar_hold_d   = bar_hold_q;
        frame_done_d = 1'b0;
        disp_we      = 1'b0;
        crossing     = prev_q < trig_level && src_val >= trig_level;
        grp_start    = (int'(pt_q) % BAR_W) == 0;
        if (src_vld) prev_d = src_val;
        unique case (disp_st_q)
            D_ARM: begin
                if (src_vld && (!trig_en || crossing)) begin
                    disp_we   = 1'b1;
                    pt_d      = PW'(1);
                    disp_st_d = D_FILL;
                end
            end
            D_FILL: begin
                if (src_vld) begin
                    disp_we = 1'b1;
                    if (pt_q == PT_LAST) begin
                        pt_d         = '0;
                        frame_done_d = 1'b1;
                        disp_st_d    = mode_freeze ? D_HOLD : D_ARM;
                    end else begin
                        pt_d = pt_q + 1'b1;
                    end
                end
            end
            D_HOLD: begin
                if (!mode_freeze) disp_st_d = D_ARM;
            end
            default: disp_st_d = D_ARM;
        endcase
        // bar mode is sampled only at group starts
        disp_wdata = src_val;
        if (disp_we) begin
            if (grp_start) begin
                bar_on_d   = mode_bar;
                bar_hold_d = src_val;
            end else if (bar_on_q) begin
                disp_wdata = bar_hold_q;
            end
        end
        rd_data_d = (int'(rd_addr) < DISP_PTS) ? disp_mem[rd_addr] : '0;
    end

    always_ff @(posedge clk_sample) begin
        if (!rst_n) begin
            rec_st_q     <= R_IDLE;
            wr_ptr_q     <= '0;
            rec_cnt_q    <= '0;
            clr_ptr_q    <= '0;
            play_ptr_q   <= '0;
            play_done_q  <= 1'b0;
            disp_st_q    <= D_ARM;
            pt_q         <= '0;
            prev_q       <= '0;
            bar_on_q     <= 1'b0;
            bar_hold_q   <= '0;
            frame_done_q <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            rec_st_q     <= rec_st_d;
            wr_ptr_q     <= wr_ptr_d;
            rec_cnt_q    <= rec_cnt_d;
            clr_ptr_q    <= clr_ptr_d;
            play_ptr_q   <= play_ptr_d;
            play_done_q  <= play_done_d;
            disp_st_q    <= disp_st_d;
            pt_q         <= pt_d;
            prev_q       <= prev_d;
            bar_on_q     <= bar_on_d;
            bar_hold_q   <= bar_hold_d;
            frame_done_q <= frame_done_d;
            rd_data_q    <= rd_data_d;
        end
    end

    always_ff @(posedge clk_sample) begin
        if (rst_n && rec_we) rec_mem[rec_waddr] <= rec_wdata;
    end

    always_ff @(posedge clk_sample) begin
        if (rst_n && disp_we) disp_mem[pt_q] <= disp_wdata;
    end

    assign rd_data    = rd_data_q;
    assign rec_count  = rec_cnt_q;
    assign rec_full   = rec_cnt_q == DEPTH_C;
    assign play_done  = play_done_q;
    assign frame_done = frame_done_q;
    assign busy_clear = rec_st_q == R_CLEAR;

endmodule

// File: tb/tb_wave_capture_buffer.sv
// Scoreboard bench for wave_capture_buffer: a frame-level reference model
// queues expected display frames; a monitor reads them back on frame_done.
module tb_wave_capture_buffer;

    localparam int DW = 8;
    localparam int RD = 16;
    localparam int DP = 8;
    localparam int BW = 4;

    typedef logic [DP-1:0][DW-1:0] frame_t;
    typedef enum {M_ARM, M_FILL, M_HOLD} mst_e;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sample_tick, record_tick;
    logic [DW-1:0] wave_sample;
    logic          mode_record, mode_playback, mode_freeze;
    logic          mode_clear, mode_bar, trig_en;
    logic [DW-1:0] trig_level;
    logic [2:0]    rd_addr;
    logic [DW-1:0] rd_data;
    logic [4:0]    rec_count;
    logic          rec_full, play_done, frame_done, busy_clear;
    logic          dump_req;

    always #5 clk = ~clk;

    wave_capture_buffer #(
        .DATA_W(DW), .REC_DEPTH(RD), .DISP_PTS(DP),
        .BAR_W(BW), .CLEAR_VAL(0)
    ) dut (
        .clk_sample(clk), .rst_n(rst_n),
        .sample_tick(sample_tick), .record_tick(record_tick),
        .wave_sample(wave_sample),
        .mode_record(mode_record), .mode_playback(mode_playback),
        .mode_freeze(mode_freeze), .mode_clear(mode_clear),
        .mode_bar(mode_bar), .trig_en(trig_en), .trig_level(trig_level),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .rec_count(rec_count), .rec_full(rec_full),
        .play_done(play_done), .frame_done(frame_done),
        .busy_clear(busy_clear)
    );

    int total = 0;
    int bad = 0;
    int frames_seen = 0;
    frame_t exp_q[$];

    // reference model state
    mst_e   m_st;
    int     m_prev;
    int     m_raw[$];
    bit     m_bar[$];
    frame_t m_disp;
    int     recm[$];
    bit     rec_on;
    int     pidx;
    bit     pdone;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_st = M_ARM;
        m_prev = 0;
        m_raw.delete();
        m_bar.delete();
        recm.delete();
        rec_on = 0;
        pidx = 0;
        pdone = 0;
    endfunction

    function automatic void finish_frame();
        for (int i = 0; i < DP; i++) begin
            int g = i / BW;
            m_disp[i] = DW'(m_bar[g] ? m_raw[g*BW] : m_raw[i]);
        end
        exp_q.push_back(m_disp);
    endfunction

    function automatic void model_src(input int v);
        case (m_st)
            M_ARM: begin
                if (!trig_en || (m_prev < int'(trig_level) &&
                                 v >= int'(trig_level))) begin
                    m_raw.delete();
                    m_bar.delete();
                    m_raw.push_back(v);
                    m_bar.push_back(mode_bar);
                    m_st = M_FILL;
                end
            end
            M_FILL: begin
                if (m_raw.size() % BW == 0) m_bar.push_back(mode_bar);
                m_raw.push_back(v);
                if (m_raw.size() == DP) begin
                    finish_frame();
                    m_st = mode_freeze ? M_HOLD : M_ARM;
                end
            end
            default: ;
        endcase
        m_prev = v;
    endfunction

    function automatic bit play_act_m();
        return mode_playback && !rec_on && recm.size() > 0;
    endfunction

    // called at a negedge; returns at a negedge
    task automatic tick(input bit live, input bit rec, input int v,
                        input int gap);
        sample_tick = live;
        record_tick = rec;
        wave_sample = DW'(v);
        if (play_act_m()) begin
            if (rec) begin
                if (pidx < recm.size()) begin
                    model_src(recm[pidx]);
                    pidx++;
                end else begin
                    model_src(0);
                    pdone = 1;
                end
            end
        end else if (live) begin
            model_src(v);
        end
        if (rec_on && rec && recm.size() < RD) recm.push_back(v & 255);
        @(negedge clk);
        sample_tick = 0;
        record_tick = 0;
        chk("play_done", play_done, pdone);
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic start_rec();
        mode_record = 1;
        recm.delete();
        pidx = 0;
        pdone = 0;
        rec_on = 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic stop_rec();
        mode_record = 0;
        repeat (2) @(negedge clk);
        rec_on = 0;
    endtask

    task automatic set_play(input bit b);
        mode_playback = b;
        if (!b) begin
            pidx = 0;
            pdone = 0;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic dump();
        exp_q.push_back(m_disp);
        dump_req = 1;
        @(posedge clk);
        #3 dump_req = 0;
        repeat (DP + 3) @(negedge clk);
    endtask

    // monitor: read back a whole frame whenever the DUT reports one
    initial begin
        frame_t e;
        int nfr = 0;
        rd_addr = 0;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n === 1'b1 && (frame_done === 1'b1 || dump_req)) begin
                if (frame_done === 1'b1) frames_seen++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL frame_unexpected: got frame %0d want none",
                             nfr);
                end else begin
                    e = exp_q.pop_front();
                    for (int i = 0; i < DP; i++) begin
                        rd_addr = 3'(i);
                        @(posedge clk);
                        #2;
                        chk($sformatf("frame%0d_pt%0d", nfr, i), rd_data, e[i]);
                    end
                    rd_addr = 0;
                end
                nfr++;
            end
        end
    end

    initial begin
        int f0, n;
        rst_n = 0;
        sample_tick = 0;
        record_tick = 0;
        wave_sample = 0;
        mode_record = 0;
        mode_playback = 0;
        mode_freeze = 0;
        mode_clear = 0;
        mode_bar = 0;
        trig_en = 0;
        trig_level = 0;
        dump_req = 0;
        m_disp = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_rec_count", rec_count, 0);
        chk("rst_rec_full", rec_full, 0);
        chk("rst_play_done", play_done, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_busy", busy_clear, 0);
        chk("rst_rd_data", rd_data, 0);
        rst_n = 1;
        @(negedge clk);

        // fill record memory past capacity
        start_rec();
        for (int i = 1; i <= 20; i++) tick(0, 1, i, 2);
        chk("full_count", rec_count, 16);
        chk("full_flag", rec_full, 1);
        stop_rec();
        chk("full_count_kept", rec_count, 16);
        // play it all back: frames 1..8, 9..16, then zeros
        set_play(1);
        for (int i = 0; i < 20; i++) tick(0, 1, $urandom_range(0, 255), 2);
        set_play(0);
        repeat (12) @(negedge clk);

        // reset mid-record and mid-frame
        start_rec();
        for (int i = 0; i < 5; i++) tick(1, 1, 200 + i, 2);
        chk("pre_rst_count", rec_count, 5);
        repeat (12) @(negedge clk);
        rst_n = 0;
        mode_record = 0;
        @(negedge clk);
        chk("mid_rst_count", rec_count, 0);
        chk("mid_rst_frame_done", frame_done, 0);
        chk("mid_rst_rd_data", rd_data, 0);
        chk("mid_rst_busy", busy_clear, 0);
        rst_n = 1;
        model_reset();
        @(negedge clk);

        // short recording played past its end
        start_rec();
        for (int i = 3; i <= 5; i++) tick(0, 1, i, 2);
        stop_rec();
        chk("pb_count", rec_count, 3);
        set_play(1);
        for (int k = 1; k <= 5; k++) begin
            tick(0, 1, 99, 2);
            chk($sformatf("pb_done_tick%0d", k), play_done, k >= 4);
        end
        for (int k = 0; k < 3; k++) tick(0, 1, 99, 2);
        set_play(0);
        repeat (12) @(negedge clk);

        // rising-level trigger
        trig_en = 1;
        trig_level = 100;
        f0 = frames_seen;
        tick(1, 0, 50, 2);
        tick(1, 0, 120, 2);
        tick(1, 0, 90, 2);
        tick(1, 0, 110, 2);
        for (int i = 0; i < 5; i++) tick(1, 0, $urandom_range(0, 255), 2);
        repeat (14) @(negedge clk);
        chk("trig_frames", frames_seen - f0, 1);
        trig_en = 0;

        // freeze plus bar quantisation
        mode_freeze = 1;
        mode_bar = 1;
        for (int i = 10; i <= 17; i++) tick(1, 0, i, 2);
        repeat (12) @(negedge clk);
        f0 = frames_seen;
        for (int i = 0; i < 20; i++) tick(1, 0, $urandom_range(0, 255), 2);
        chk("hold_no_frames", frames_seen - f0, 0);
        dump();
        mode_freeze = 0;
        if (m_st == M_HOLD) m_st = M_ARM;
        @(negedge clk);
        for (int i = 0; i < 8; i++) tick(1, 0, 77 + i, 2);
        mode_bar = 0;
        repeat (12) @(negedge clk);

        // clear ignored while recording, then a full clear
        start_rec();
        tick(0, 1, 31, 2);
        tick(0, 1, 32, 2);
        mode_clear = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("clear_ignored_busy", busy_clear, 0);
        end
        tick(0, 1, 33, 2);
        mode_clear = 0;
        tick(0, 1, 34, 2);
        stop_rec();
        chk("clr_pre_count", rec_count, 4);
        mode_clear = 1;
        @(negedge clk);
        mode_clear = 0;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (busy_clear) n++;
            @(negedge clk);
        end
        chk("clear_busy_cycles", n, 16);
        chk("clear_count", rec_count, 0);
        chk("clear_full", rec_full, 0);
        recm.delete();

        // randomised mix of live, record and playback activity
        for (int it = 0; it < 25; it++) begin
            case ($urandom_range(0, 2))
                0: begin
                    trig_en = 1'($urandom_range(0, 1));
                    trig_level = 8'($urandom_range(0, 255));
                    repeat ($urandom_range(4, 20)) begin
                        if ($urandom_range(0, 9) == 0) mode_bar = ~mode_bar;
                        tick(1, 0, $urandom_range(0, 255), $urandom_range(2, 4));
                    end
                end
                1: begin
                    start_rec();
                    n = $urandom_range(1, 20);
                    repeat (n) tick(1'($urandom_range(0, 1)), 1,
                                    $urandom_range(0, 255), 2);
                    chk("rnd_rec_count", rec_count, (n > RD) ? RD : n);
                    chk("rnd_rec_full", rec_full, n >= RD);
                    stop_rec();
                end
                default: begin
                    set_play(1);
                    repeat ($urandom_range(3, 24))
                        tick(1'($urandom_range(0, 1)), 1,
                             $urandom_range(0, 255), $urandom_range(2, 3));
                    set_play(0);
                end
            endcase
        end

        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
